lfsr_rng_stream: RTL and testbench

LFSR_RNG_STREAM -- requirements
Module: lfsr_rng_stream

---
 rtl/lfsr_rng_stream.sv | 106 ++++++++++
 tb/tb_lfsr_rng_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_stream.sv
// lfsr_rng_stream: Galois LFSR random bit source that packs successive
// output bits into OUT_W-bit words offered through a valid/ready slot.
// Bits are assembled LSB-first in time: the first bit of a word ends up
// in rnd_number[0].
module lfsr_rng_stream #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = 64'hD800_0000_0000_0000,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_number,
  output logic             rbit,
  output logic             lockup
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] num_q, num_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [OUT_W-1:0] asm_shift;
  logic             at_last;
  logic             slot_free;
  logic             step;

  // Next-state logic: seed load wins over stepping; the last bit of a word
  // only advances when the output slot can take the completed word.
  always_comb begin
    lfsr_next = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    asm_shift = (asm_q >> 1) | (OUT_W'(state_q[0]) << (OUT_W - 1));
    at_last   = (cnt_q == CW'(OUT_W - 1));
    slot_free = !valid_q || rnd_ready;
    step      = en && !seed_load && (!at_last || slot_free);

    state_d  = state_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    num_d    = num_q;
    lockup_d = lockup_q;

    if (valid_q && rnd_ready) begin
      valid_d = 1'b0;
    end

    if (seed_load) begin
      // An all-zero seed would lock the LFSR; substitute SEED and flag it.
      if (seed_in == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = seed_in;
        lockup_d = 1'b0;
      end
      cnt_d = '0;
      asm_d = '0;
    end else if (step) begin
      state_d = lfsr_next;
      asm_d   = asm_shift;
      if (at_last) begin
        cnt_d   = '0;
        num_d   = asm_shift;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      asm_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      num_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      num_q    <= num_d;
      lockup_q <= lockup_d;
    end
  end

  assign rnd_valid  = valid_q;
  assign rnd_number = num_q;
  assign rbit       = state_q[0];
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Testbench for lfsr_rng_stream (WIDTH=8, TAPS=B8, SEED=01, OUT_W=4).
module tb_lfsr_rng_stream;

  localparam int W  = 8;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          rnd_ready = 1'b0;
  logic          rnd_valid;
  logic [OW-1:0] rnd_number;
  logic          rbit;
  logic          lockup;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            accepted = 0;

  lfsr_rng_stream #(
    .WIDTH(W), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_number(rnd_number),
    .rbit(rbit), .lockup(lockup)
  );

  always #5 clk = ~clk;

  // Reference: one LFSR step straight from the stepping rule.
  function automatic logic [W-1:0] lstep(input logic [W-1:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [W-1:0] state_after(input logic [W-1:0] s0, input int n);
    logic [W-1:0] s = s0;
    for (int i = 0; i < n; i++) s = lstep(s);
    return s;
  endfunction

  // Word k of the stream: bits k*OW .. k*OW+OW-1, earliest bit in the LSB.
  function automatic logic [OW-1:0] word_at(input logic [W-1:0] s0, input int k);
    logic [W-1:0]  s = state_after(s0, k * OW);
    logic [OW-1:0] w = '0;
    for (int j = 0; j < OW; j++) begin
      w[j] = s[0];
      s = lstep(s);
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; seed_load = 1'b0; rnd_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks that a
  // held word stays stable under back-pressure.
  logic          hold_prev = 1'b0;
  logic [OW-1:0] num_prev = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_valid", rnd_valid, 1'b1);
        chk("hold_stable", rnd_number, num_prev);
      end
      if (rnd_valid && rnd_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("sb_word", rnd_number, exp_q.pop_front());
          accepted++;
        end
      end
      hold_prev = rnd_valid && !rnd_ready;
      num_prev  = rnd_number;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] seq [5];
    logic [W-1:0] s;
    logic [W-1:0] rs;
    int early;

    seq[0] = 8'hB8; seq[1] = 8'h5C; seq[2] = 8'h2E; seq[3] = 8'h17; seq[4] = 8'hB3;

    // Reset values and the first word
    seed_load = 1'b1; en = 1'b1;
    do_reset();
    seed_load = 1'b0;
    chk("rst_state", dut.state_q, 8'h01);
    chk("rst_rbit", rbit, 1'b1);
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_number", rnd_number, 0);
    chk("rst_lockup", lockup, 1'b0);
    en = 1'b1; rnd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("seq_state%0d", i), dut.state_q, seq[i]);
      if (i == 2) chk("valid_not_early", rnd_valid, 1'b0);
      if (i == 3) begin
        chk("first_valid", rnd_valid, 1'b1);
        chk("first_word", rnd_number, 4'b0001);
      end
    end

    // Full period
    do_reset();
    en = 1'b1; rnd_ready = 1'b1;
    early = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 255 && dut.state_q == 8'h01) early++;
    end
    chk("period_final", dut.state_q, 8'h01);
    chk("period_early_repeats", early, 0);

    // Back-pressure
    do_reset();
    en = 1'b1; rnd_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("bp_valid", rnd_valid, 1'b1);
    chk("bp_cnt", dut.cnt_q, 3);
    chk("bp_state", dut.state_q, state_after(8'h01, 7));
    chk("bp_number", rnd_number, word_at(8'h01, 0));
    rnd_ready = 1'b1;
    tick();
    chk("bp_next_valid", rnd_valid, 1'b1);
    chk("bp_next_word", rnd_number, word_at(8'h01, 1));
    tick();
    chk("bp_drained", rnd_valid, 1'b0);

    // Zero-seed recovery then a normal seed
    en = 1'b0; seed_load = 1'b1; seed_in = 8'h00;
    tick();
    chk("zseed_state", dut.state_q, 8'h01);
    chk("zseed_lockup", lockup, 1'b1);
    seed_in = 8'h5A; en = 1'b1;
    tick();
    chk("seed_state", dut.state_q, 8'h5A);
    chk("seed_lockup", lockup, 1'b0);
    chk("seed_cnt", dut.cnt_q, 0);
    seed_load = 1'b0;

    // Reset overrides a pending word, partial word and seed_load
    do_reset();
    en = 1'b1; rnd_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_valid", rnd_valid, 1'b1);
    chk("pre_rst_cnt", dut.cnt_q, 2);
    rst = 1'b1; seed_load = 1'b1; seed_in = 8'h5A;
    tick();
    rst = 1'b0; seed_load = 1'b0; en = 1'b0;
    chk("mid_rst_state", dut.state_q, 8'h01);
    chk("mid_rst_valid", rnd_valid, 1'b0);
    chk("mid_rst_number", rnd_number, 0);
    chk("mid_rst_lockup", lockup, 1'b0);
    chk("mid_rst_cnt", dut.cnt_q, 0);
    chk("mid_rst_rbit", rbit, 1'b1);

    // Enable freeze mid-word
    do_reset();
    en = 1'b1; rnd_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    s = dut.state_q;
    en = 1'b0; rnd_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("frz_state", dut.state_q, state_after(8'h01, 6));
    chk("frz_state_same", dut.state_q, s);
    chk("frz_cnt", dut.cnt_q, 2);
    chk("frz_valid", rnd_valid, 1'b0);
    chk("frz_number", rnd_number, word_at(8'h01, 0));
    en = 1'b1;
    tick(); tick();
    chk("frz_resume_valid", rnd_valid, 1'b1);
    chk("frz_resume_word", rnd_number, word_at(8'h01, 1));

    // Randomized runs: reset seed, random seed, zero seed
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rs = 8'h01;
      if (r > 0) begin
        rs = (r == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        seed_load = 1'b1; seed_in = rs;
        tick();
        seed_load = 1'b0;
        chk("rand_lockup", lockup, (rs == 8'h00));
        if (rs == 8'h00) rs = 8'h01;
      end
      exp_q.delete();
      for (int k = 0; k < 200; k++) exp_q.push_back(word_at(rs, k));
      accepted = 0;
      mon_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
        en = ($urandom_range(0, 3) != 0);
        rnd_ready = ($urandom_range(0, 1) != 0);
        tick();
      end
      en = 1'b0; rnd_ready = 1'b0;
      tick();
      mon_en = 1'b0;
      chk("rand_progress", (accepted > 20), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
